// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
// Picks one requester from an N-bit request bitmap, in fixed-priority or
// round-robin order, and holds that grant in an output register until the
// consumer acks it. An ack that arrives while requests are still pending
// registers the next grant on the same edge, so back-to-back grants have
// no idle bubble. The round-robin base pointer advances past the acked
// index, and wraps at WIDTH rather than at 2^IDX_W.

module rr_priority_encoder #(
  parameter int WIDTH      = 40,
  parameter int IDX_W      = 6,
  parameter bit RESET_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] req,
  input  logic             mode_wr,
  input  logic             mode_in,
  input  logic             ack,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [WIDTH-1:0] grant_onehot,
  output logic [IDX_W-1:0] ptr
);

  // IDLE: no grant held. HOLD: a grant is held until it is acked.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Search sums are kept one bit wider than an index, so base + offset
  // cannot overflow before it is wrapped back into 0..WIDTH-1.
  localparam logic [IDX_W:0]   WIDTH_X  = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // Advance an index by one, wrapping from WIDTH-1 to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // Return the first set bit of r, searching base, base+1, ..., WIDTH-1,
  // 0, ..., base-1. A base of 0 gives fixed priority (lowest index wins).
  // When r is empty the result is 0. Callers only use it when r is non-empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [WIDTH-1:0] r,
                                               input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   cand;
    logic             found;
    logic [IDX_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cand = {1'b0, base} + (IDX_W+1)'(i);
      if (cand >= WIDTH_X) begin
        cand = cand - WIDTH_X;
      end
      if (!found && r[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
    return win;
  endfunction

  // Registered state.
  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [WIDTH-1:0] grant_onehot_q, grant_onehot_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             mode_q, mode_d;

  // Combinational helpers.
  logic             ack_take;
  logic             eligible;
  logic [IDX_W-1:0] sel_base;
  logic [IDX_W-1:0] sel_win;
  logic [WIDTH-1:0] sel_onehot;

  // Compute the mode, the pointer and the candidate winner for this edge.
  // NOTE: every variable gets a default at the top of always_comb. Without
  // one, a path that skips an assignment would infer a latch.
  always_comb begin
    ack_take = 1'b0;
    mode_d   = mode_q;
    ptr_d    = ptr_q;
    eligible = 1'b0;
    sel_base = '0;

    // An ack only counts while a grant is held. An ack in IDLE changes nothing.
    ack_take = (state_q == HOLD) && ack;

    // A new mode applies to the selection made on this same edge.
    if (mode_wr) begin
      mode_d = mode_in;
    end

    // The pointer advance depends on the mode that was in force when the
    // acked grant was issued, which is the old mode.
    if (ack_take && mode_q) begin
      ptr_d = wrap_inc(grant_idx_q);
    end

    eligible = enable && (|req);

    // A back-to-back selection searches from the already-advanced pointer.
    sel_base = mode_d ? ptr_d : '0;
  end

  assign sel_win    = rr_pick(req, sel_base);
  assign sel_onehot = WIDTH'(1) << sel_win;

  // Next-state logic for the grant register: load, hold, or release it.
  always_comb begin
    state_d        = state_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;

    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d        = HOLD;
          grant_idx_d    = sel_win;
          grant_onehot_d = sel_onehot;
        end
      end
      HOLD: begin
        // Without an ack the grant stays frozen, whatever req and enable do.
        if (ack_take) begin
          if (eligible) begin
            state_d        = HOLD;
            grant_idx_d    = sel_win;
            grant_onehot_d = sel_onehot;
          end else begin
            state_d        = IDLE;
            grant_idx_d    = '0;
            grant_onehot_d = '0;
          end
        end
      end
      default: begin
        state_d        = IDLE;
        grant_idx_d    = '0;
        grant_onehot_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset. A reset discards any
  // held grant without an ack.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge and the result does not depend on
  // the order in which the simulator runs the blocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      ptr_q          <= '0;
      mode_q         <= RESET_MODE;
    end else begin
      state_q        <= state_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      ptr_q          <= ptr_d;
      mode_q         <= mode_d;
    end
  end

  assign grant_valid  = (state_q == HOLD);
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;
  assign ptr          = ptr_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Testbench for rr_priority_encoder.
// A behavioural model tracks the grant, pointer and mode with integers and
// a modulo search. It runs one step per clock edge, and its results are
// compared with every output after each edge. Directed sequences with
// literal expectations come first, then randomized traffic.

module tb_rr_priority_encoder;

  localparam int WIDTH = 40;
  localparam int IDX_W = 6;
  localparam bit RESET_MODE = 1'b0;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] req;
  logic             mode_wr;
  logic             mode_in;
  logic             ack;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_onehot;
  logic [IDX_W-1:0] ptr;

  int checks = 0;
  int errors = 0;

  // Model state.
  bit m_valid;
  int m_idx;
  int m_ptr;
  bit m_mode;

  rr_priority_encoder #(
    .WIDTH     (WIDTH),
    .IDX_W     (IDX_W),
    .RESET_MODE(RESET_MODE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .mode_wr     (mode_wr),
    .mode_in     (mode_in),
    .ack         (ack),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_onehot(grant_onehot),
    .ptr         (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return the first requester found by walking the indices
  // base, base+1, ... modulo WIDTH. Return -1 when nobody requests.
  function automatic int pick(input logic [WIDTH-1:0] r, input int base);
    for (int k = 0; k < WIDTH; k++) begin
      int j;
      j = (base + k) % WIDTH;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge, using the inputs at that edge.
  task automatic model_update();
    bit new_mode;
    if (!rst) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_mode  = RESET_MODE;
    end else begin
      new_mode = mode_wr ? mode_in : m_mode;
      if (m_valid && ack && m_mode) m_ptr = (m_idx + 1) % WIDTH;
      if (!m_valid || ack) begin
        if (enable && req != '0) begin
          m_valid = 1'b1;
          m_idx   = pick(req, new_mode ? m_ptr : 0);
        end else begin
          m_valid = 1'b0;
          m_idx   = 0;
        end
      end
      m_mode = new_mode;
    end
  endtask

  // Clock one edge, update the model, and compare every output just after the edge.
  task automatic step(input string tag);
    logic [63:0] exp_oh;
    @(posedge clk);
    model_update();
    #1;
    exp_oh = m_valid ? (64'd1 << m_idx) : 64'd0;
    check({tag, ".valid"}, 64'(grant_valid), 64'(m_valid));
    check({tag, ".idx"}, 64'(grant_idx), 64'(m_idx));
    check({tag, ".onehot"}, 64'(grant_onehot), exp_oh);
    check({tag, ".ptr"}, 64'(ptr), 64'(m_ptr));
    check({tag, ".idx_range"}, 64'(grant_idx < IDX_W'(WIDTH)), 64'd1);
  endtask

  function automatic logic [WIDTH-1:0] rand40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] bit40(input int i);
    logic [63:0] t;
    t = 64'd1 << i;
    return t[WIDTH-1:0];
  endfunction

  initial begin
    rst = 1'b0; enable = 1'b0; req = '0; mode_wr = 1'b0; mode_in = 1'b0; ack = 1'b0;
    m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_mode = RESET_MODE;

    // Reset held for two cycles, then an empty request with enable high.
    step("reset0");
    step("reset1");
    rst = 1'b1; enable = 1'b1; req = '0;
    for (int i = 0; i < 3; i++) begin
      step("empty");
      check("empty.valid_lit", 64'(grant_valid), 64'd0);
      check("empty.ptr_lit", 64'(ptr), 64'd0);
    end

    // Fixed priority: the lowest set bit wins, and an ack does not move ptr.
    req = 40'h80_0000_0024;
    step("fixed");
    check("fixed.idx_lit", 64'(grant_idx), 64'd2);
    check("fixed.oh_lit", 64'(grant_onehot), 64'h4);
    ack = 1'b1;
    step("fixed_ack");
    check("fixed_ack.idx_lit", 64'(grant_idx), 64'd2);
    check("fixed_ack.ptr_lit", 64'(ptr), 64'd0);
    req = '0;
    step("fixed_drain");
    check("fixed_drain.valid_lit", 64'(grant_valid), 64'd0);

    // Round-robin rotation over bits {2,5,39}, with ack every cycle.
    ack = 1'b0; mode_wr = 1'b1; mode_in = 1'b1;
    step("to_rr");
    mode_wr = 1'b0;
    req = bit40(2) | bit40(5) | bit40(39);
    step("rr0");
    check("rr0.idx_lit", 64'(grant_idx), 64'd2);
    ack = 1'b1;
    step("rr1");
    check("rr1.idx_lit", 64'(grant_idx), 64'd5);
    step("rr2");
    check("rr2.idx_lit", 64'(grant_idx), 64'd39);
    step("rr3");
    check("rr3.idx_lit", 64'(grant_idx), 64'd2);
    check("rr3.ptr_wrap_lit", 64'(ptr), 64'd0);
    step("rr4");
    check("rr4.idx_lit", 64'(grant_idx), 64'd5);

    // The held grant stays frozen while req changes and no ack arrives.
    ack = 1'b0;
    req = bit40(1) | bit40(2);
    for (int i = 0; i < 4; i++) begin
      step("hold");
      check("hold.idx_lit", 64'(grant_idx), 64'd5);
      check("hold.valid_lit", 64'(grant_valid), 64'd1);
    end
    ack = 1'b1;
    step("hold_ack");
    check("hold_ack.ptr_lit", 64'(ptr), 64'd6);
    check("hold_ack.idx_lit", 64'(grant_idx), 64'd1);

    // Release the grant, then test enable gating and an ack while IDLE.
    req = '0;
    step("release");
    enable = 1'b0; req = '1; ack = 1'b1; mode_wr = 1'b1; mode_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("gated");
      check("gated.valid_lit", 64'(grant_valid), 64'd0);
      check("gated.ptr_lit", 64'(ptr), 64'd2);
    end
    mode_wr = 1'b0; ack = 1'b0; enable = 1'b1;
    step("ungated");
    check("ungated.idx_lit", 64'(grant_idx), 64'd0);
    check("ungated.valid_lit", 64'(grant_valid), 64'd1);
    rst = 1'b0;
    step("midreset");
    check("midreset.valid_lit", 64'(grant_valid), 64'd0);
    check("midreset.oh_lit", 64'(grant_onehot), 64'd0);
    rst = 1'b1;

    // A mode write and an ack on the same edge: the pointer update uses
    // the old mode, and the new selection uses the new mode.
    enable = 1'b1; mode_wr = 1'b1; mode_in = 1'b1; req = bit40(9);
    step("ms_setup0");
    mode_wr = 1'b0; ack = 1'b1; req = bit40(3) | bit40(12) | bit40(20);
    step("ms_setup1");
    check("ms_setup1.idx_lit", 64'(grant_idx), 64'd12);
    check("ms_setup1.ptr_lit", 64'(ptr), 64'd10);
    ack = 1'b1; mode_wr = 1'b1; mode_in = 1'b0;
    step("ms_switch");
    check("ms_switch.ptr_lit", 64'(ptr), 64'd13);
    check("ms_switch.idx_lit", 64'(grant_idx), 64'd3);
    ack = 1'b0; mode_wr = 1'b0;

    // Randomized traffic, checked against the model.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) != 0);
      enable  = ($urandom_range(0, 9) < 8);
      ack     = $urandom_range(0, 1) != 0;
      mode_wr = ($urandom_range(0, 19) == 0);
      mode_in = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 4))
        0: req = '0;
        1: req = bit40($urandom_range(0, WIDTH - 1));
        2: req = rand40() & rand40() & rand40();
        3: req = rand40();
        default: req = bit40(WIDTH - 1) | bit40($urandom_range(0, WIDTH - 1));
      endcase
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Parametrised successor to the fixed 40-to-6 priority encoder used by issue/wavepool selection.
- Picks one requester per grant from an N-bit request vector, in fixed-priority or round-robin mode, and holds the grant in an output register.
- The held grant is released only by a valid/ack handshake.
- Sits between wavefront-ready bitmaps and the issue/fetch consumers that need a stable index for more than one cycle.

Parameters:
- WIDTH, 40, number of request lines.
- IDX_W, 6, width of the encoded index; must satisfy 2^IDX_W >= WIDTH.
- RESET_MODE, 0, value loaded into the mode register at reset (0 = fixed, 1 = round-robin).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 at the rising edge resets the block).
- enable  input  1  selection allowed this cycle; 0 blocks new grants but does not drop a held grant.
- req  input  WIDTH  request bitmap, bit i = requester i ready.
- mode_wr  input  1  load mode register from mode_in.
- mode_in  input  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- ack  input  1  consumer accepts the current grant.
- grant_valid  output  1  grant register holds a valid grant.
- grant_idx  output  IDX_W  encoded index of the granted requester.
- grant_onehot  output  WIDTH  one-hot form of grant_idx; all zeros when grant_valid==0.
- ptr  output  IDX_W  current round-robin base pointer (debug/verification visibility).

Behaviour:
- Reset (rst==0 at clk edge):
  - grant_valid=0, grant_idx=0, grant_onehot=0, ptr=0, mode=RESET_MODE.
  - Reset mid-grant discards the grant with no ack required.
- States: IDLE (grant_valid=0) and HOLD (grant_valid=1).
- IDLE:
  - If enable && |req, compute the winner combinationally and register it; next cycle grant_valid=1 (1-cycle latency req->grant).
  - Otherwise stay IDLE with outputs zero. There is never an X output: an empty or disabled request produces idx 0, valid 0.
- Winner selection:
  - Fixed mode: lowest set index in req.
  - Round-robin mode: first set bit searching ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1 (wrap at WIDTH, not at 2^IDX_W).
- HOLD:
  - grant_idx and grant_onehot stay frozen regardless of req or enable changes. A deasserted req bit does not revoke the grant; the consumer owns it.
  - On ack: the grant is consumed that cycle.
  - On ack with enable && |req (with the granted bit masked out only if it is still set? no): re-evaluation uses the live req, and a new grant is registered the same edge. This gives back-to-back grants with no idle bubble; grant_valid stays 1.
  - On ack with no eligible request, go to IDLE.
- Pointer:
  - Updates only on ack in round-robin mode: ptr <= (grant_idx==WIDTH-1) ? 0 : grant_idx+1.
  - Fixed mode leaves ptr unchanged.
  - The back-to-back re-evaluation on an ack cycle uses the updated pointer value, i.e. grant_idx+1 computed combinationally, not the stale ptr.
- ack while grant_valid==0 is ignored (no state change, ptr unchanged).
- mode_wr:
  - Takes effect from the next selection.
  - Does not alter a held grant or ptr.
  - mode_wr and ack in the same cycle: the pointer update uses the old mode; the new selection uses the new mode.
- Width rules:
  - Indices are compared and incremented at IDX_W bits with explicit wrap at WIDTH.
  - Unused encodings (WIDTH..2^IDX_W-1) are never produced.

Test Plan:
- Reset/empty: hold rst=0 2 cycles, then req=0, enable=1 -> grant_valid=0, grant_idx=0, grant_onehot=0, ptr=0 every cycle.
- Fixed priority: mode=0, req=40'h80_0000_0024 -> next cycle grant_idx=2, onehot bit 2. Ack -> ptr stays 0, next grant_idx=2 again (req unchanged).
- Round-robin rotation: mode=1, req bits {2,5,39} constant, ack every cycle -> grant sequence 2,5,39,2,5. After the grant of 39 is acked, ptr=0 (wrap).
- Hold stability: grant_idx=5 held, drop req bit 5 and set bit 1, no ack for 4 cycles -> grant_idx stays 5, valid stays 1. Then ack -> next grant_idx=1 (ptr=6 wraps search to 1).
- Enable gating and reset mid-grant: enable=0 with req=all-ones -> valid stays 0. Enable=1 -> grant 0. Assert rst=0 during HOLD -> next cycle all outputs 0, ptr=0.
- Mode switch with ack same cycle: mode=1, ptr=10, held grant 12, req bits {3,12,20}, mode_wr=1 mode_in=0 with ack -> ptr=13, new grant_idx=3 (fixed priority).
